// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM (Moore) with registered control outputs.
module mc_controller #(
  parameter int ZEXT_LOGIC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       branch,
  output logic       branchne,
  output logic       pcwrite,
  output logic       zext,
  output logic       pcen,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12,
    ANDIEX  = 4'd13,
    ORIEX   = 4'd14,
    SLTIEX  = 4'd15
  } state_t;
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic       branch;
    logic       branchne;
    logic       pcwrite;
    logic       zext;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;
  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 3'b010; end
      RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BEQEX:   begin c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branch = 1'b1; end
      BNEEX:   begin c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branchne = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ANDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 3'b100; c.zext = (ZEXT_LOGIC != 0); end
      ORIEX:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 3'b011; c.zext = (ZEXT_LOGIC != 0); end
      SLTIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 3'b101; end
      IMMWB:   c.regwrite = 1'b1;
      JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE:
        case (op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = RTYPEEX;
          6'b000100:            state_d = BEQEX;
          6'b000101:            state_d = BNEEX;
          6'b001000:            state_d = ADDIEX;
          6'b001100:            state_d = ANDIEX;
          6'b001101:            state_d = ORIEX;
          6'b001010:            state_d = SLTIEX;
          6'b000010:            state_d = JEX;
          default:              state_d = FETCH;
        endcase
      MEMADR:                         state_d = (op == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:                          state_d = MEMWB;
      RTYPEEX:                        state_d = RTYPEWB;
      ADDIEX, ANDIEX, ORIEX, SLTIEX:  state_d = IMMWB;
      default:                        state_d = FETCH;
    endcase
  end
  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= decode(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end
  // FETCH strobes are held off while reset is high; everything else already idles.
  assign irwrite  = ctrl_q.irwrite & ~reset;
  assign pcwrite  = ctrl_q.pcwrite & ~reset;
  assign iord     = ctrl_q.iord;
  assign memwrite = ctrl_q.memwrite;
  assign regwrite = ctrl_q.regwrite;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign alusrca  = ctrl_q.alusrca;
  assign branch   = ctrl_q.branch;
  assign branchne = ctrl_q.branchne;
  assign zext     = ctrl_q.zext;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign aluop    = ctrl_q.aluop;
  assign pcen     = pcwrite | (branch & zero) | (branchne & ~zero);
  assign state    = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized checks of mc_controller against an instruction-level model.
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic       branch, branchne, pcwrite, zext, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state;
  logic [17:0] obs;
  int checks = 0;
  int errors = 0;
  logic [5:0] legal_ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                 6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .branch(branch),
    .branchne(branchne), .pcwrite(pcwrite), .zext(zext), .pcen(pcen),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .state(state)
  );
  always #5 clk = ~clk;
  assign obs = {iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                branch, branchne, pcwrite, zext, alusrcb, pcsrc, aluop};
  function automatic logic [17:0] exp_ctrl(input int s);
    logic id = 0, irw = 0, mw = 0, rw = 0, rd = 0, m2r = 0, sa = 0, br = 0, bn = 0, pw = 0, zx = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] ao = 0;
    case (s)
      0:  begin sb = 2'b01; irw = 1; pw = 1; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  id = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin id = 1; mw = 1; end
      6:  begin sa = 1; ao = 3'b010; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ao = 3'b001; ps = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      12: begin sa = 1; ao = 3'b001; ps = 2'b01; bn = 1; end
      13: begin sa = 1; sb = 2'b10; ao = 3'b100; zx = 1; end
      14: begin sa = 1; sb = 2'b10; ao = 3'b011; zx = 1; end
      15: begin sa = 1; sb = 2'b10; ao = 3'b101; end
      default: ;
    endcase
    return {id, irw, mw, rw, rd, m2r, sa, br, bn, pw, zx, sb, ps, ao};
  endfunction
  // Whole-instruction state trace, FETCH onward, as listed by instruction class.
  task automatic path_of(input logic [5:0] o, output int p[6], output int n);
    p = '{0, 1, 0, 0, 0, 0};
    n = 3;
    case (o)
      6'b100011: begin p[2] = 2; p[3] = 3; p[4] = 4; n = 5; end
      6'b101011: begin p[2] = 2; p[3] = 5; n = 4; end
      6'b000000: begin p[2] = 6; p[3] = 7; n = 4; end
      6'b000100: p[2] = 8;
      6'b000101: p[2] = 12;
      6'b000010: p[2] = 11;
      6'b001000: begin p[2] = 9;  p[3] = 10; n = 4; end
      6'b001100: begin p[2] = 13; p[3] = 10; n = 4; end
      6'b001101: begin p[2] = 14; p[3] = 10; n = 4; end
      6'b001010: begin p[2] = 15; p[3] = 10; n = 4; end
      default:   n = 2;
    endcase
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  // Walks path entries k0..kstop-1; op is only meaningful in DECODE/MEMADR and is scrambled elsewhere.
  task automatic check_path(input logic [5:0] o, input int zm, input int k0, input int kstop);
    int p[6];
    int n;
    logic ep;
    path_of(o, p, n);
    for (int k = k0; k < n && k < kstop; k++) begin
      op = (p[k] == 1 || p[k] == 2) ? o : 6'($urandom);
      zero = (zm == 2) ? 1'($urandom) : zm[0];
      #1;
      ep = (p[k] == 0 || p[k] == 11) || (p[k] == 8 && zero) || (p[k] == 12 && !zero);
      checks++;
      if (state !== 4'(p[k])) begin
        errors++;
        $display("FAIL state op=%b step=%0d: got %0d expected %0d", o, k, state, p[k]);
      end
      checks++;
      if (obs !== exp_ctrl(p[k])) begin
        errors++;
        $display("FAIL ctrl op=%b state=%0d: got %b expected %b", o, p[k], obs, exp_ctrl(p[k]));
      end
      checks++;
      if (pcen !== ep) begin
        errors++;
        $display("FAIL pcen op=%b state=%0d zero=%b: got %b expected %b", o, p[k], zero, pcen, ep);
      end
      step();
    end
    if (kstop >= n) begin
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL return op=%b: got state %0d expected 0", o, state);
      end
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    checks++;
    if (state !== 4'd0 || obs !== 18'b000000000000100000 || pcen !== 1'b0) begin
      errors++;
      $display("FAIL %s: state=%0d ctrl=%b pcen=%b expected state 0 ctrl 000000000000100000 pcen 0",
               tag, state, obs, pcen);
    end
  endtask
  task automatic test_reset();
    #1 reset = 1'b1;
    #1 check_reset_outputs("reset_async");
    step();
    step();
    check_reset_outputs("reset_held");
    reset = 1'b0;
    op = 6'b100011;
    #1;
    checks++;
    if (obs !== exp_ctrl(0) || pcen !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ctrl=%b pcen=%b expected %b pcen 1", obs, pcen, exp_ctrl(0));
    end
  endtask
  task automatic test_directed();
    check_path(6'b100011, 0, 0, 9);
    check_path(6'b000100, 1, 0, 9);
    check_path(6'b000100, 0, 0, 9);
    check_path(6'b000101, 1, 0, 9);
    check_path(6'b000101, 0, 0, 9);
    check_path(6'b001101, 0, 0, 9);
    check_path(6'b111111, 1, 0, 9);
    check_path(6'b101011, 0, 0, 9);
    check_path(6'b000010, 0, 0, 9);
  endtask
  task automatic test_random();
    logic [5:0] o;
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(9)];
      check_path(o, 2, 0, 9);
    end
  endtask
  task automatic test_reset_midflight();
    check_path(6'b101011, 0, 0, 3);
    checks++;
    if (state !== 4'd5 || memwrite !== 1'b1) begin
      errors++;
      $display("FAIL midflight_pre: state=%0d memwrite=%b expected 5 and 1", state, memwrite);
    end
    op = 6'b100011;
    #1 reset = 1'b1;
    #1 check_reset_outputs("midflight_reset");
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || obs !== exp_ctrl(0)) begin
      errors++;
      $display("FAIL midflight_release: state=%0d ctrl=%b expected 0 %b", state, obs, exp_ctrl(0));
    end
    step();
    check_path(6'b100011, 0, 1, 9);
  endtask
  task automatic test_back_to_back();
    check_path(6'b000000, 2, 0, 9);
    check_path(6'b001100, 2, 0, 9);
    check_path(6'b001010, 2, 0, 9);
    check_path(6'b001000, 2, 0, 9);
    check_path(6'b000000, 2, 0, 9);
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter ZEXT_LOGIC, default 1: 1 = andi/ori states assert zext; 0 = zext always 0.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port op  input  6  instruction opcode, instr[31:26].
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have outputs iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, branch, branchne, pcwrite, zext, pcen, each 1 bit.
REQ-007 SHALL have outputs alusrcb (2 bits), pcsrc (2 bits), aluop (3 bits), state (4 bits, debug).

Function
REQ-008 SHALL be a Moore FSM, one 4-bit state register updated on the rising edge of clk.
REQ-009 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IMMWB=10, JEX=11, BNEEX=12, ANDIEX=13, ORIEX=14, SLTIEX=15.
REQ-010 The state output SHALL equal the state register.
REQ-011 aluop encoding is shared with the ALU decoder: 000 add, 001 sub, 010 R-type (use funct), 011 or, 100 and, 101 slt.
REQ-012 Transitions:
- FETCH->DECODE.
- DECODE by op: 100011/101011->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 000101->BNEEX; 001000->ADDIEX; 001100->ANDIEX; 001101->ORIEX; 001010->SLTIEX; 000010->JEX; any other op->FETCH (no writes).
REQ-013 Transitions:
- MEMADR->MEMRD if op=100011, else MEMWR.
- MEMRD->MEMWB.
- RTYPEEX->RTYPEWB.
- ADDIEX, ANDIEX, ORIEX, SLTIEX->IMMWB.
- MEMWB, MEMWR, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX->FETCH.
REQ-014 Outputs per state; any output not listed SHALL be 0:
- FETCH: alusrcb=01, irwrite=1, pcwrite=1.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
REQ-015 Outputs per state (continued); any output not listed SHALL be 0:
- RTYPEEX: alusrca=1, aluop=010.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=001, pcsrc=01, branch=1.
- BNEEX: alusrca=1, aluop=001, pcsrc=01, branchne=1.
REQ-016 Outputs per state (continued); any output not listed SHALL be 0:
- ADDIEX: alusrca=1, alusrcb=10.
- ANDIEX: alusrca=1, alusrcb=10, aluop=100, zext=ZEXT_LOGIC.
- ORIEX: alusrca=1, alusrcb=10, aluop=011, zext=ZEXT_LOGIC.
- SLTIEX: alusrca=1, alusrcb=10, aluop=101.
- IMMWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-017 pcen SHALL be combinational: pcwrite | (branch & zero) | (branchne & ~zero).
REQ-018 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL NOT affect the next state.
REQ-019 Instruction latency, counted in cycles from FETCH to return to FETCH:
- lw = 5.
- sw, R-type, addi, andi, ori, slti = 4.
- beq, bne, j = 3.
- illegal op = 2.

Reset
REQ-020 Asserting reset SHALL set state=FETCH immediately, without waiting for a clock edge.
REQ-021 While reset is high, irwrite, pcwrite, memwrite, regwrite and pcen SHALL be 0; all other outputs SHALL be 0 except alusrcb=01.
REQ-022 If reset is asserted in any state, the in-flight instruction SHALL be abandoned with no further writes.
REQ-023 After reset deasserts, the first clk edge SHALL move the FSM FETCH->DECODE, with FETCH outputs active in the cycle before that edge.

Verification
REQ-024 op=100011 after reset -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-025 op=000100, zero=1 -> in state 8, pcen=1, pcsrc=01, aluop=001; repeat with zero=0 -> pcen=0.
REQ-026 op=000101, zero=1 -> pcen=0 in state 12; with zero=0 -> pcen=1.
REQ-027 op=001101 -> states 0,1,14,10,0; aluop=011 and zext=1 in state 14; regwrite=1 in state 10.
REQ-028 op=111111 -> states 0,1,0; memwrite, regwrite and pcen never asserted in DECODE.
REQ-029 Reset pulsed mid-cycle while in state 5 -> state=0 and memwrite=0 before the next clk edge; the normal sequence resumes after release.
